// File: rtl/adder_operand_loader.sv
// Operand loader for the wide adder stage: assembles a/b from narrow beats,
// least-significant word first, and offers each finished pair over valid/ready.
module adder_operand_loader #(
    parameter  int ADDER_WIDTH = 117,
    parameter  int WORD_W      = 32,
    localparam int NUM_WORDS   = (ADDER_WIDTH + WORD_W - 1) / WORD_W,
    localparam int IDX_W       = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WORD_W-1:0]      in_a_word,
    input  logic [WORD_W-1:0]      in_b_word,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ADDER_WIDTH-1:0] a,
    output logic [ADDER_WIDTH-1:0] b,
    output logic [IDX_W-1:0]       word_idx
);

    typedef enum logic {
        LOAD = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

    state_t state, state_next;
    logic   beat_accept;
    logic   last_beat;

    // flush outranks both a same-cycle beat and a same-cycle output handshake.
    assign beat_accept = in_valid & in_ready & ~flush;
    assign last_beat   = (word_idx == LAST_IDX);

    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent simulation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= LOAD;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: default assignment first, so no path through the block leaves
    // state_next unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        if (flush) begin
            state_next = LOAD;
        end else begin
            case (state)
                LOAD:    if (beat_accept && last_beat) state_next = HOLD;
                HOLD:    if (out_ready)                state_next = LOAD;
                default: state_next = LOAD;
            endcase
        end
    end

    // Decoding from state keeps out_valid glitch-free and lets the async reset
    // drop it immediately, without waiting for an edge.
    always_comb begin
        in_ready  = (state == LOAD);
        out_valid = (state == HOLD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_idx <= '0;
        end else if (flush) begin
            word_idx <= '0;
        end else if (beat_accept) begin
            word_idx <= last_beat ? '0 : word_idx + IDX_W'(1);
        end
    end

    // One register slice per beat; the top slice is narrower, so surplus beat
    // bits of the final word have nowhere to land.
    for (genvar g = 0; g < NUM_WORDS; g++) begin : g_seg
        localparam int LO    = g * WORD_W;
        localparam int SEG_W = (g == NUM_WORDS - 1) ? (ADDER_WIDTH - LO) : WORD_W;

        logic [SEG_W-1:0] a_seg;
        logic [SEG_W-1:0] b_seg;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                a_seg <= '0;
                b_seg <= '0;
            end else if (beat_accept && (word_idx == IDX_W'(g))) begin
                a_seg <= in_a_word[SEG_W-1:0];
                b_seg <= in_b_word[SEG_W-1:0];
            end
        end

        assign a[LO +: SEG_W] = a_seg;
        assign b[LO +: SEG_W] = b_seg;
    end

endmodule

// File: tb/tb_adder_operand_loader.sv
// Bench for adder_operand_loader: directed steps plus random gapped traffic,
// checked against a beat-queue reference model.
module tb_adder_operand_loader;

    localparam int ADDER_WIDTH = 117;
    localparam int WORD_W      = 32;
    localparam int NUM_WORDS   = 4;
    localparam int IDX_W       = 2;
    localparam logic [127:0] FULL = (128'd1 << ADDER_WIDTH) - 128'd1;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   flush;
    logic                   in_valid;
    logic                   in_ready;
    logic [WORD_W-1:0]      in_a_word;
    logic [WORD_W-1:0]      in_b_word;
    logic                   out_valid;
    logic                   out_ready;
    logic [ADDER_WIDTH-1:0] a;
    logic [ADDER_WIDTH-1:0] b;
    logic [IDX_W-1:0]       word_idx;

    adder_operand_loader #(.ADDER_WIDTH(ADDER_WIDTH), .WORD_W(WORD_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a_word (in_a_word),
        .in_b_word (in_b_word),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .a         (a),
        .b         (b),
        .word_idx  (word_idx)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int n_pairs = 0;

    // Reference model: beats collected so far, and the pending pair if any.
    bit           m_hold = 1'b0;
    logic [31:0]  qa[$];
    logic [31:0]  qb[$];
    logic [127:0] pend_a = '0;
    logic [127:0] pend_b = '0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_hold = 1'b0;
        qa.delete();
        qb.delete();
    endtask

    // Drive one cycle of inputs, advance the model, then check outputs after the edge.
    task automatic cycle(input bit v, input logic [31:0] wa, input logic [31:0] wb,
                         input bit ordy, input bit fl);
        in_valid  = v;
        in_a_word = wa;
        in_b_word = wb;
        out_ready = ordy;
        flush     = fl;
        if (!fl && m_hold && ordy) begin
            check("pair_a", 128'(a), pend_a & FULL);
            check("pair_b", 128'(b), pend_b & FULL);
            n_pairs++;
        end
        if (fl) begin
            model_reset();
        end else if (m_hold) begin
            if (ordy) m_hold = 1'b0;
        end else if (v) begin
            qa.push_back(wa);
            qb.push_back(wb);
            if (qa.size() == NUM_WORDS) begin
                pend_a = '0;
                pend_b = '0;
                for (int i = 0; i < NUM_WORDS; i++) begin
                    pend_a = pend_a + (128'(qa[i]) << (WORD_W * i));
                    pend_b = pend_b + (128'(qb[i]) << (WORD_W * i));
                end
                qa.delete();
                qb.delete();
                m_hold = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        check("out_valid", 128'(out_valid), 128'(m_hold));
        check("in_ready",  128'(in_ready),  128'(!m_hold));
        check("word_idx",  128'(word_idx),  128'(qa.size()));
    endtask

    initial begin
        int start_pairs;
        int budget;

        // 1: reset with random inputs
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid  = 1'($urandom);
            in_a_word = $urandom;
            in_b_word = $urandom;
            out_ready = 1'($urandom);
            flush     = 1'($urandom);
            @(posedge clk);
            #1;
            check("rst_out_valid", 128'(out_valid), 128'd0);
            check("rst_in_ready",  128'(in_ready),  128'd1);
            check("rst_a",         128'(a),         128'd0);
            check("rst_b",         128'(b),         128'd0);
            check("rst_word_idx",  128'(word_idx),  128'd0);
        end
        in_valid = 1'b0;
        flush    = 1'b0;
        rst_n    = 1'b1;
        model_reset();

        // 2: full load, final beat truncated
        cycle(1, 32'd1, 32'd0, 1, 0);
        cycle(1, 32'd2, 32'd0, 1, 0);
        cycle(1, 32'd3, 32'd0, 1, 0);
        cycle(1, 32'hFFFF_FFFF, 32'd0, 1, 0);
        check("full_a", 128'(a), 128'h1F_FFFF_0000_0003_0000_0002_0000_0001);
        check("full_b", 128'(b), 128'd0);
        cycle(0, 32'd0, 32'd0, 1, 0);
        check("full_one_cycle", 128'(out_valid), 128'd0);

        // 3: backpressure for 10 cycles with in_valid held high
        for (int i = 0; i < NUM_WORDS; i++) cycle(1, $urandom, $urandom, 0, 0);
        for (int i = 0; i < 10; i++) begin
            cycle(1, 32'hDEAD_BEEF, 32'hCAFE_F00D, 0, 0);
            check("hold_a", 128'(a), pend_a & FULL);
            check("hold_b", 128'(b), pend_b & FULL);
        end
        cycle(1, 32'hDEAD_BEEF, 32'hCAFE_F00D, 1, 0);
        cycle(1, 32'h1234_5678, 32'h8765_4321, 1, 0);
        check("bp_next_beat_idx", 128'(word_idx), 128'd1);
        cycle(0, 32'd0, 32'd0, 1, 1);

        // 4: flush with a same-cycle beat, then a fresh load
        cycle(1, 32'hAAAA_0001, 32'hBBBB_0001, 1, 0);
        cycle(1, 32'hAAAA_0002, 32'hBBBB_0002, 1, 0);
        cycle(1, 32'hAAAA_0003, 32'hBBBB_0003, 1, 1);
        check("flush_idx", 128'(word_idx), 128'd0);
        for (int i = 0; i < NUM_WORDS; i++) cycle(1, 32'h5000_0000 + i, 32'h6000_0000 + i, 0, 0);
        check("flush_fresh_a", 128'(a), 128'h0_5000_0003_5000_0002_5000_0001_5000_0000 & FULL);
        cycle(0, 32'd0, 32'd0, 1, 0);

        // 5: randomly gapped input and output over 50 pairs
        start_pairs = n_pairs;
        budget      = 0;
        while (n_pairs < start_pairs + 50 && budget < 3000) begin
            cycle(1'($urandom_range(0, 1)), $urandom, $urandom, 1'($urandom_range(0, 1)), 0);
            budget++;
        end
        check("gapped_pairs_done", 128'(n_pairs - start_pairs >= 50), 128'd1);

        // 6: async reset while holding a pair
        cycle(1, 32'd0, 32'd0, 1, 1);
        for (int i = 0; i < NUM_WORDS; i++) cycle(1, $urandom, $urandom, 0, 0);
        check("pre_async_hold", 128'(out_valid), 128'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_out_valid", 128'(out_valid), 128'd0);
        check("async_in_ready",  128'(in_ready),  128'd1);
        check("async_a",         128'(a),         128'd0);
        check("async_word_idx",  128'(word_idx),  128'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < NUM_WORDS; i++) cycle(1, $urandom, $urandom, 1, 0);
        cycle(0, 32'd0, 32'd0, 1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
